// File: rtl/arm_imm_encoder.sv
// Iterative encoder for ARM data-processing rotated immediates: searches rotate_imm 0..15
// for an 8-bit immediate. Define ARM_IMM_ENCODER_FAST_EN to short-cut values already below 256.
module arm_imm_encoder (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] value,
  input  logic        carryFlag,
  output logic        busy,
  output logic        done,
  output logic        encodable,
  output logic [11:0] shifter_operand,
  output logic        carry
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SEARCH = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  logic [1:0]  state;
  logic [31:0] v_reg;
  logic        c_reg;
  logic [3:0]  rot_cnt;

  logic [4:0]  rot_amt;
  logic [63:0] dbl;
  logic [31:0] rol;
  logic        match;

  // ROL(v, 2r) taken as the upper half of {v, v} shifted left
  always_comb begin
    rot_amt = {rot_cnt, 1'b0};
    dbl     = {v_reg, v_reg} << rot_amt;
    rol     = dbl[63:32];
    match   = (rol[31:8] == 24'd0);
  end

  assign busy = (state == SEARCH) || (state == DONE);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      v_reg           <= '0;
      c_reg           <= 1'b0;
      rot_cnt         <= '0;
      encodable       <= 1'b0;
      shifter_operand <= '0;
      carry           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            v_reg   <= value;
            c_reg   <= carryFlag;
            rot_cnt <= '0;
`ifdef ARM_IMM_ENCODER_FAST_EN
            if (value[31:8] == 24'd0) begin
              encodable       <= 1'b1;
              shifter_operand <= {4'h0, value[7:0]};
              carry           <= carryFlag;
              state           <= DONE;
            end else begin
              state <= SEARCH;
            end
`else
            state <= SEARCH;
`endif
          end
        end
        SEARCH: begin
          if (match) begin
            encodable       <= 1'b1;
            shifter_operand <= {rot_cnt, rol[7:0]};
            carry           <= (rot_cnt == 4'd0) ? c_reg : v_reg[31];
            state           <= DONE;
          end else if (rot_cnt == 4'hF) begin
            encodable       <= 1'b0;
            shifter_operand <= '0;
            carry           <= c_reg;
            state           <= DONE;
          end else begin
            rot_cnt <= rot_cnt + 4'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arm_imm_encoder.sv
// Directed self-checking bench for arm_imm_encoder: encodings, latencies, ignored start,
// back-to-back requests and asynchronous reset during a search.
module tb_arm_imm_encoder;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [31:0] value;
  logic        carryFlag;
  logic        busy;
  logic        done;
  logic        encodable;
  logic [11:0] shifter_operand;
  logic        carry;

  int checks;
  int errors;

`ifdef ARM_IMM_ENCODER_FAST_EN
  localparam int SHORT_LAT = 1;
`else
  localparam int SHORT_LAT = 2;
`endif

  arm_imm_encoder dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .start           (start),
    .value           (value),
    .carryFlag       (carryFlag),
    .busy            (busy),
    .done            (done),
    .encodable       (encodable),
    .shifter_operand (shifter_operand),
    .carry           (carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; start is accepted at the next posedge.
  task automatic run_enc(input string tag, input logic [31:0] v, input logic cf,
                         input logic e_enc, input logic [11:0] e_so, input logic e_c,
                         input int e_lat);
    int cnt;
    value     = v;
    carryFlag = cf;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt   = 1;
    while (done !== 1'b1 && cnt < 40) begin
      chk({tag, "_busy_search"}, busy, 1);
      @(negedge clk);
      cnt++;
    end
    chk({tag, "_done"}, done, 1);
    chk({tag, "_latency"}, cnt, e_lat);
    chk({tag, "_busy_done"}, busy, 1);
    chk({tag, "_encodable"}, encodable, e_enc);
    chk({tag, "_operand"}, shifter_operand, e_so);
    chk({tag, "_carry"}, carry, e_c);
    @(negedge clk);
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_busy_idle"}, busy, 0);
    chk({tag, "_hold"}, shifter_operand, e_so);
  endtask

  initial begin
    int cnt;
    logic seen;
    checks    = 0;
    errors    = 0;
    reset_n   = 1'b0;
    start     = 1'b0;
    value     = '0;
    carryFlag = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_encodable", encodable, 0);
    chk("rst_operand", shifter_operand, 0);
    chk("rst_carry", carry, 0);
    reset_n = 1'b1;
    @(negedge clk);

    run_enc("ff",       32'h000000FF, 1'b1, 1'b1, 12'h0FF, 1'b1, SHORT_LAT);
    run_enc("ff000000", 32'hFF000000, 1'b0, 1'b1, 12'h4FF, 1'b1, 6);
    run_enc("104",      32'h00000104, 1'b1, 1'b1, 12'hF41, 1'b0, 17);
    run_enc("101_c1",   32'h00000101, 1'b1, 1'b0, 12'h000, 1'b1, 17);
    run_enc("101_c0",   32'h00000101, 1'b0, 1'b0, 12'h000, 1'b0, 17);
    run_enc("f000000f", 32'hF000000F, 1'b0, 1'b1, 12'h2FF, 1'b1, 4);
    run_enc("80000000", 32'h80000000, 1'b0, 1'b1, 12'h102, 1'b1, 3);
    run_enc("zero",     32'h00000000, 1'b1, 1'b1, 12'h000, 1'b1, SHORT_LAT);

    // Second start during SEARCH is ignored; input changes meanwhile have no effect
    value     = 32'hFF000000;
    carryFlag = 1'b0;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt   = 1;
    @(negedge clk);
    cnt++;
    value     = 32'h00000001;
    carryFlag = 1'b1;
    start     = 1'b1;
    @(negedge clk);
    cnt++;
    start = 1'b0;
    while (done !== 1'b1 && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    chk("ignore_done", done, 1);
    chk("ignore_latency", cnt, 6);
    chk("ignore_operand", shifter_operand, 12'h4FF);
    chk("ignore_carry", carry, 1);
    @(negedge clk);
    chk("ignore_no_requeue", done, 0);
    // Start issued in the IDLE cycle right after done
    run_enc("b2b_1", 32'h00000001, 1'b0, 1'b1, 12'h001, 1'b0, SHORT_LAT);

    // Leave known nonzero outputs so the reset clearing is observable
    run_enc("pre_rst", 32'h000000FF, 1'b1, 1'b1, 12'h0FF, 1'b1, SHORT_LAT);
    value     = 32'h00000101;
    carryFlag = 1'b1;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("midsearch_busy", busy, 1);
    chk("midsearch_hold", shifter_operand, 12'h0FF);
    #2 reset_n = 1'b0;
    #1;
    chk("async_busy", busy, 0);
    chk("async_done", done, 0);
    chk("async_encodable", encodable, 0);
    chk("async_operand", shifter_operand, 0);
    chk("async_carry", carry, 0);
    @(negedge clk);
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    chk("post_rst_quiet", seen, 0);
    run_enc("post_rst", 32'h000000FF, 1'b1, 1'b1, 12'h0FF, 1'b1, SHORT_LAT);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
